// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a
// valid/ready pipeline register with flush and an illegal-instruction counter.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_f3,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_alu_code,
    output logic             out_rf_we,
    output logic             out_mem_re,
    output logic             out_mem_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      f3;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_code;
        logic            rf_we;
        logic            mem_re;
        logic            mem_we;
        logic            illegal;
    } payload_t;

    payload_t dec;
    payload_t pay_d, pay_q;
    logic valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic accept;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_opi, is_op;
    logic bad, writes;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    assign is_lui   = (opc == OP_LUI);
    assign is_auipc = (opc == OP_AUIPC);
    assign is_jal   = (opc == OP_JAL);
    assign is_jalr  = (opc == OP_JALR);
    assign is_br    = (opc == OP_BRANCH);
    assign is_ld    = (opc == OP_LOAD);
    assign is_st    = (opc == OP_STORE);
    assign is_opi   = (opc == OP_OPIMM);
    assign is_op    = (opc == OP_OP);

    always_comb begin
        imm32 = 32'b0;
        bad   = 1'b0;
        unique case (1'b1)
            is_lui, is_auipc: imm32 = imm_u;
            is_jal:           imm32 = imm_j;
            is_jalr: begin
                imm32 = imm_i;
                bad   = (f3 != 3'b000);
            end
            is_br: begin
                imm32 = imm_b;
                bad   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            is_ld: begin
                imm32 = imm_i;
                bad   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            is_st: begin
                imm32 = imm_s;
                bad   = (f3 >= 3'b011);
            end
            is_opi: begin
                imm32 = imm_i;
                if (f3 == 3'b001)
                    bad = (f7 != F7_BASE);
                else if (f3 == 3'b101)
                    bad = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            is_op: begin
                if (f7 == F7_ALT)
                    bad = (f3 != 3'b000) && (f3 != 3'b101);
                else if (f7 == F7_MUL)
                    bad = !ENABLE_M;
                else
                    bad = (f7 != F7_BASE);
            end
            default: bad = 1'b1;
        endcase
    end

    assign writes = is_lui | is_auipc | is_jal | is_jalr
                  | is_ld | is_opi | is_op;

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.opcode   = opc;
        dec.f3       = f3;
        dec.rd       = in_instr[11:7];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.imm      = XLEN'($signed(imm32));
        dec.illegal  = bad;
        dec.rf_we    = writes && (in_instr[11:7] != 5'd0) && !bad;
        dec.mem_re   = is_ld && !bad;
        dec.mem_we   = is_st && !bad;
        dec.alu_code = 5'b00000;
        if (is_br)
            dec.alu_code = 5'b01000;
        else if (is_op)
            dec.alu_code = {f7 == F7_MUL, in_instr[30], f3};
        else if (is_opi)
            dec.alu_code = {1'b0, (f3 == 3'b101) && in_instr[30], f3};
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        pay_d   = pay_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pay_d   = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // Saturate rather than wrap so a long illegal storm stays visible.
        if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pay_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pay_q   <= pay_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pay_q.pc;
    assign out_opcode    = pay_q.opcode;
    assign out_f3        = pay_q.f3;
    assign out_rd        = pay_q.rd;
    assign out_rs1       = pay_q.rs1;
    assign out_rs2       = pay_q.rs2;
    assign out_imm       = pay_q.imm;
    assign out_alu_code  = pay_q.alu_code;
    assign out_rf_we     = pay_q.rf_we;
    assign out_mem_re    = pay_q.mem_re;
    assign out_mem_we    = pay_q.mem_we;
    assign out_illegal   = pay_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: base config plus an M-enabled,
// 2-bit-counter instance driven by the same stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        a_in_ready, a_out_valid, a_rf_we, a_mem_re, a_mem_we, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opcode;
    logic [2:0]  a_f3;
    logic [4:0]  a_rd, a_rs1, a_rs2, a_alu;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_rf_we, b_mem_re, b_mem_we, b_illegal;
    logic [31:0] b_pc, b_imm;
    logic [6:0]  b_opcode;
    logic [2:0]  b_f3;
    logic [4:0]  b_rd, b_rs1, b_rs2, b_alu;
    logic [1:0]  b_cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_opcode(a_opcode), .out_f3(a_f3), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm),
        .out_alu_code(a_alu), .out_rf_we(a_rf_we), .out_mem_re(a_mem_re),
        .out_mem_we(a_mem_we), .out_illegal(a_illegal), .illegal_count(a_cnt)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(2)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_opcode(b_opcode), .out_f3(b_f3), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm),
        .out_alu_code(b_alu), .out_rf_we(b_rf_we), .out_mem_re(b_mem_re),
        .out_mem_we(b_mem_we), .out_illegal(b_illegal), .illegal_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", a_out_valid, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_ready", a_in_ready, 1);
        chk("rst_imm", a_imm, 0);

        out_ready = 1'b1;
        drive(32'hFFF00093, 32'h100);
        tick();
        chk("addi_valid", a_out_valid, 1);
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_alu", a_alu, 5'b00000);
        chk("addi_rd", a_rd, 1);
        chk("addi_we", a_rf_we, 1);
        chk("addi_pc", a_pc, 32'h100);
        drive(32'h402081B3, 32'h104);
        tick();
        chk("sub_valid", a_out_valid, 1);
        chk("sub_pc", a_pc, 32'h104);
        chk("sub_alu", a_alu, 5'b01000);
        chk("sub_we", a_rf_we, 1);
        chk("sub_rd", a_rd, 3);
        chk("sub_rs1", a_rs1, 1);
        chk("sub_rs2", a_rs2, 2);
        chk("sub_imm", a_imm, 0);

        drive(32'hFE000CE3, 32'h108);
        tick();
        chk("beq_imm", a_imm, 32'hFFFFFFF8);
        chk("beq_alu", a_alu, 5'b01000);
        chk("beq_we", a_rf_we, 0);
        out_ready = 1'b0;
        drive(32'h00500293, 32'h10C);
        #1;
        chk("bp_ready", a_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", a_out_valid, 1);
            chk("bp_imm", a_imm, 32'hFFFFFFF8);
            chk("bp_pc", a_pc, 32'h108);
            chk("bp_ready_hold", a_in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", a_in_ready, 1);
        tick();
        chk("bp_next_pc", a_pc, 32'h10C);
        chk("bp_next_imm", a_imm, 5);
        chk("bp_next_rd", a_rd, 5);

        drive(32'h00000000, 32'h110);
        tick();
        chk("ill0", a_illegal, 1);
        chk("ill0_we", a_rf_we, 0);
        drive(32'h02208033, 32'h114);
        tick();
        chk("mul_nom_ill", a_illegal, 1);
        chk("mul_nom_we", a_rf_we, 0);
        chk("mul_m_ill", b_illegal, 0);
        chk("mul_m_alu", b_alu, 5'b10000);
        drive(32'h40209033, 32'h118);
        tick();
        chk("subf3_ill", a_illegal, 1);
        chk("subf3_we", a_rf_we, 0);
        in_valid = 1'b0;
        tick();
        chk("ill_cnt", a_cnt, 3);
        chk("ill_cnt_m", b_cnt, 2);
        chk("drain_valid", a_out_valid, 0);

        drive(32'h00500293, 32'h11C);
        tick();
        chk("pre_flush_valid", a_out_valid, 1);
        flush = 1'b1;
        drive(32'h00000000, 32'h120);
        tick();
        flush = 1'b0;
        chk("flush_valid", a_out_valid, 0);
        chk("flush_cnt", a_cnt, 3);
        chk("flush_cnt_m", b_cnt, 2);

        drive(32'h0020A223, 32'h124);
        tick();
        chk("sw_imm", a_imm, 4);
        chk("sw_we", a_mem_we, 1);
        chk("sw_rfwe", a_rf_we, 0);
        drive(32'hFFC0A303, 32'h128);
        tick();
        chk("lw_imm", a_imm, 32'hFFFFFFFC);
        chk("lw_re", a_mem_re, 1);
        chk("lw_rfwe", a_rf_we, 1);
        drive(32'h800003B7, 32'h12C);
        tick();
        chk("lui_imm", a_imm, 32'h80000000);
        chk("lui_rd", a_rd, 7);

        drive(32'h00000000, 32'h130);
        tick();
        chk("sat_cnt_m_a", b_cnt, 3);
        tick();
        tick();
        in_valid = 1'b0;
        chk("sat_cnt_m", b_cnt, 3);
        chk("nosat_cnt", a_cnt, 6);

        drive(32'h00500293, 32'h134);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        chk("hold_valid", a_out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", a_out_valid, 0);
        chk("mrst_cnt", a_cnt, 0);
        chk("mrst_cnt_m", b_cnt, 0);
        chk("mrst_imm", a_imm, 0);
        chk("mrst_pc", a_pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
